// File: rtl/alu_op_sequencer.sv
// Request/response sequencer driving an external combinational N-bit ALU; 1-cycle ops, N-cycle shift-add multiply.
// Optional multiply is compiled in with `define ALU_SEQ_MUL_EN; otherwise req_mul is ignored.
module alu_op_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_ctrl,
  input  logic         req_cin,
  input  logic         req_mul,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_f,
  output logic [N-1:0] rsp_hi,
  output logic         rsp_c,
  output logic         rsp_v,
  output logic         rsp_z,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [2:0]   alu_ctrl,
  input  logic [N-1:0] alu_f,
  input  logic         alu_cout,
  input  logic         alu_v,
  input  logic         alu_z
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  state_t state;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // During MUL, alu_a doubles as P_hi and alu_b as the multiplicand M.
  logic [N-1:0]  p_lo;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sum;
  logic          c;
  logic [N-1:0]  nxt_hi;
  logic [N-1:0]  nxt_lo;

  always_comb begin
    sum    = p_lo[0] ? alu_f : alu_a;
    c      = p_lo[0] ? alu_cout : 1'b0;
    nxt_hi = {c, sum[N-1:1]};
    nxt_lo = {sum[0], p_lo[N-1:1]};
  end
`else
  logic unused_mul;
  assign unused_mul = req_mul;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_f     <= '0;
      rsp_hi    <= '0;
      rsp_c     <= 1'b0;
      rsp_v     <= 1'b0;
      rsp_z     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_ctrl  <= 3'b000;
`ifdef ALU_SEQ_MUL_EN
      p_lo      <= '0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_ctrl  <= req_ctrl;
            alu_cin   <= req_cin;
            state     <= EXEC;
`ifdef ALU_SEQ_MUL_EN
            if (req_mul) begin
              alu_a    <= '0;
              alu_b    <= req_a;
              alu_ctrl <= 3'b000;
              alu_cin  <= 1'b0;
              p_lo     <= req_b;
              cnt      <= '0;
              state    <= MUL;
            end
`endif
          end
        end
        EXEC: begin
          rsp_f     <= alu_f;
          rsp_hi    <= '0;
          rsp_c     <= alu_cout;
          rsp_v     <= alu_v;
          rsp_z     <= alu_z;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          alu_a <= nxt_hi;
          p_lo  <= nxt_lo;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            rsp_hi    <= nxt_hi;
            rsp_f     <= nxt_lo;
            rsp_c     <= |nxt_hi;
            rsp_v     <= 1'b0;
            rsp_z     <= ~|{nxt_hi, nxt_lo};
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
